// File: rtl/latch_write_sequencer.sv
// Drives a transparent D latch from a noisy asynchronous input: synchronise, debounce,
// then run a fixed setup/open/hold write so d is stable around the whole en window.
module latch_write_sequencer #(
    parameter int DEBOUNCE = 4,
    parameter int SETUP    = 1,
    parameter int OPEN     = 2,
    parameter int HOLD     = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic din_raw,
    input  logic wr_req,
    output logic d,
    output logic en,
    output logic busy
);

    localparam int MAX_SO = (SETUP > OPEN) ? SETUP : OPEN;
    localparam int MAX_SOH = (MAX_SO > HOLD) ? MAX_SO : HOLD;
    localparam int MAX_ALL = (MAX_SOH > DEBOUNCE) ? MAX_SOH : DEBOUNCE;
    localparam int TW = $clog2(MAX_ALL) + 1;
    localparam int CW = $clog2(DEBOUNCE) + 1;

    localparam logic [TW-1:0] SETUP_T = TW'(SETUP - 1);
    localparam logic [TW-1:0] OPEN_T  = TW'(OPEN - 1);
    localparam logic [TW-1:0] HOLD_T  = TW'(HOLD - 1);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_OPEN,
        S_HOLD
    } state_t;

    logic          s1, s_q, stable;
    logic [CW-1:0] cnt;

    state_t        state, state_next;
    logic [TW-1:0] timer, timer_next;
    logic          pend, pend_next;
    logic          d_next, en_next;
    logic          start;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1     <= 1'b0;
            s_q    <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
        end else begin
            s1  <= din_raw;
            s_q <= s1;
            if (s_q == stable) begin
                cnt <= '0;
            end else if (cnt == DEB_LAST) begin
                stable <= s_q;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            timer <= '0;
            pend  <= 1'b0;
            d     <= 1'b0;
            en    <= 1'b0;
        end else begin
            state <= state_next;
            timer <= timer_next;
            pend  <= pend_next;
            d     <= d_next;
            en    <= en_next;
        end
    end

    always_comb begin
        state_next = state;
        timer_next = timer;
        d_next     = d;
        en_next    = en;
        start      = 1'b0;
        case (state)
            S_IDLE: begin
                if ((stable != d) || pend) begin
                    start      = 1'b1;
                    d_next     = stable;
                    timer_next = SETUP_T;
                    state_next = S_SETUP;
                end
            end
            S_SETUP: begin
                if (timer == '0) begin
                    en_next    = 1'b1;
                    timer_next = OPEN_T;
                    state_next = S_OPEN;
                end else begin
                    timer_next = timer - TW'(1);
                end
            end
            S_OPEN: begin
                if (timer == '0) begin
                    en_next    = 1'b0;
                    timer_next = HOLD_T;
                    state_next = S_HOLD;
                end else begin
                    timer_next = timer - TW'(1);
                end
            end
            S_HOLD: begin
                if (timer == '0) begin
                    state_next = S_IDLE;
                end else begin
                    timer_next = timer - TW'(1);
                end
            end
            default: state_next = S_IDLE;
        endcase
        // a request landing on the start cycle survives for the next sequence
        pend_next = (pend & ~start) | wr_req;
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_latch_write_sequencer.sv
// Bench for latch_write_sequencer: directed scenarios with literal expectations plus
// randomized stimulus, all checked every cycle against a position-in-sequence model.
module tb_latch_write_sequencer;

    localparam int DEBOUNCE = 4;
    localparam int SETUP    = 1;
    localparam int OPEN     = 2;
    localparam int HOLD     = 1;
    localparam int TOTAL    = SETUP + OPEN + HOLD;

    logic clk = 1'b0;
    logic rst, din_raw, wr_req;
    logic d, en, busy;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    latch_write_sequencer #(
        .DEBOUNCE(DEBOUNCE),
        .SETUP   (SETUP),
        .OPEN    (OPEN),
        .HOLD    (HOLD)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .din_raw(din_raw),
        .wr_req (wr_req),
        .d      (d),
        .en     (en),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    // Model: din pipeline history, run length of disagreement, and the cycle position
    // inside an active write sequence.
    int m_s1 = 0, m_sq = 0, m_stable = 0, m_run = 0;
    int m_d = 0, m_pend = 0, m_active = 0, m_pos = 0, m_last_rst = 1;

    always @(posedge clk) begin : model
        int s1, sq, st, run, dd, pend, act, pos, start;
        s1 = m_s1; sq = m_sq; st = m_stable; run = m_run;
        dd = m_d; pend = m_pend; act = m_active; pos = m_pos;
        if (rst) begin
            s1 = 0; sq = 0; st = 0; run = 0; dd = 0; pend = 0; act = 0; pos = 0;
        end else begin
            start = (!act && (st != dd || pend != 0)) ? 1 : 0;
            if (act != 0) begin
                pos++;
                if (pos == TOTAL) act = 0;
            end
            if (start != 0) begin
                dd = st; act = 1; pos = 0;
            end
            pend = ((start != 0) ? 0 : pend) | int'(wr_req);
            if (sq == st) run = 0;
            else begin
                run++;
                if (run == DEBOUNCE) begin
                    st = sq; run = 0;
                end
            end
            sq = s1;
            s1 = int'(din_raw);
        end
        m_s1 <= s1; m_sq <= sq; m_stable <= st; m_run <= run;
        m_d <= dd; m_pend <= pend; m_active <= act; m_pos <= pos;
        m_last_rst <= int'(rst);
    end

    logic prev_d = 1'b0, prev_en = 1'b0;

    always @(negedge clk) begin
        if (check_en) begin
            check("model_d", d, m_d != 0);
            check("model_busy", busy, m_active != 0);
            check("model_en", en, (m_active != 0) && m_pos >= SETUP && m_pos < SETUP + OPEN);
            if (d !== prev_d && m_last_rst == 0)
                check("en_low_around_d_change", en | prev_en, 1'b0);
        end
        prev_d  = d;
        prev_en = en;
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // din_raw set just before edge 0; literal timing of the first write afterwards
    task automatic directed_rise();
        din_raw = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("rise_d", d, i >= DEBOUNCE + 2);
            check("rise_en", en, i == 7 || i == 8);
            check("rise_busy", busy, i >= 6 && i <= 9);
        end
    endtask

    task automatic wait_en(input int limit);
        bit seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clk);
            if (en === 1'b1) seen = 1'b1;
        end
        check("en_seen_within_bound", seen, 1'b1);
    endtask

    initial begin
        rst = 1'b1; din_raw = 1'b0; wr_req = 1'b0;
        cycles(3);
        check_en = 1'b1;
        check("reset_d", d, 1'b0);
        check("reset_en", en, 1'b0);
        check("reset_busy", busy, 1'b0);
        rst = 1'b0;

        // idle with din_raw low: nothing happens
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_busy", busy, 1'b0);
            check("idle_d", d, 1'b0);
        end

        directed_rise();
        cycles(3);

        din_raw = 1'b0;
        cycles(15);
        check("fall_written_d", d, 1'b0);

        // short glitch is discarded
        din_raw = 1'b1;
        cycles(3);
        din_raw = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            check("glitch_busy", busy, 1'b0);
            check("glitch_en", en, 1'b0);
        end

        // level drops back while the 0->1 write is open: two sequences result
        din_raw = 1'b1;
        wait_en(20);
        din_raw = 1'b0;
        cycles(3);
        check("coalesce_first_d", d, 1'b1);
        cycles(20);
        check("coalesce_final_d", d, 1'b0);
        check("coalesce_final_busy", busy, 1'b0);

        // explicit rewrite of an unchanged value, plus one request during HOLD
        din_raw = 1'b1;
        cycles(15);
        check("pre_wr_d", d, 1'b1);
        wr_req = 1'b1;
        @(negedge clk);
        wr_req = 1'b0;
        check("wr_pending_busy", busy, 1'b0);
        @(negedge clk);
        check("wr_start_busy", busy, 1'b1);
        check("wr_start_d", d, 1'b1);
        cycles(2);
        check("wr_open_en", en, 1'b1);
        @(negedge clk);
        check("wr_hold_busy", busy, 1'b1);
        check("wr_hold_en", en, 1'b0);
        wr_req = 1'b1;
        @(negedge clk);
        wr_req = 1'b0;
        check("wr_gap_busy", busy, 1'b0);
        @(negedge clk);
        check("wr_second_busy", busy, 1'b1);
        cycles(3);
        check("wr_second_end_busy", busy, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("wr_no_third_busy", busy, 1'b0);
        end

        // reset in the middle of the open window
        wr_req = 1'b1;
        @(negedge clk);
        wr_req = 1'b0;
        wait_en(10);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_en", en, 1'b0);
        check("midrst_d", d, 1'b0);
        check("midrst_busy", busy, 1'b0);
        rst = 1'b0;
        directed_rise();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int run_len;
            run_len = int'($urandom_range(1, 10));
            din_raw = ~din_raw;
            for (int j = 0; j < run_len; j++) begin
                rst    = ($urandom_range(0, 399) == 0);
                wr_req = ($urandom_range(0, 29) == 0);
                @(negedge clk);
            end
            if (i % 300 == 299) begin
                rst = 1'b0; wr_req = 1'b0;
                cycles(DEBOUNCE + TOTAL + 6);
            end
        end
        rst = 1'b0; wr_req = 1'b0;
        cycles(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
